// File: rtl/row_router_addr_gen.sv
`default_nettype none
// row_router_addr_gen: walks one lane's k x k convolution window and emits one linear
// input-SRAM address per element over valid/ready. Zero-padding support: `define ROUTER_PAD_EN.
module row_router_addr_gen #(
    parameter int ADDR_WIDTH      = 8,
    parameter int SRAM_ADDR_WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic                       i_en,
    input  logic [ADDR_WIDTH-1:0]      i_o_x,
    input  logic [ADDR_WIDTH-1:0]      i_o_y,
    input  logic [ADDR_WIDTH-1:0]      i_i_size,
    input  logic [ADDR_WIDTH-1:0]      i_k_size,
    input  logic [ADDR_WIDTH-1:0]      i_stride,
`ifdef ROUTER_PAD_EN
    input  logic [ADDR_WIDTH-1:0]      i_pad,
    output logic                       o_pad_zero,
`endif
    input  logic                       i_ready,
    output logic [SRAM_ADDR_WIDTH-1:0] o_addr,
    output logic                       o_valid,
    output logic                       o_done
);
    localparam int RW = 2 * ADDR_WIDTH;
    localparam int SW = 2 * ADDR_WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_GEN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      ox_q, ox_d, oy_q, oy_d;
    logic [ADDR_WIDTH-1:0]      size_q, size_d, k_q, k_d, stride_q, stride_d;
    logic [ADDR_WIDTH-1:0]      kx_q, kx_d, ky_q, ky_d;
    // Base coordinates are two's complement so a padded window can start above/left of the map.
    logic [SW-1:0]              base_row_q, base_row_d, base_col_q, base_col_d;
    logic [RW-1:0]              row_addr_q, row_addr_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       valid_q, valid_d, done_q, done_d;
    logic [SW-1:0]              w_pad_ext;
    logic [RW-1:0]              w_lin;
`ifdef ROUTER_PAD_EN
    logic [ADDR_WIDTH-1:0]      pad_q, pad_d;
    logic                       pad_zero_q, pad_zero_d;
    logic [SW-1:0]              w_row, w_col;
    logic                       w_in_map;

    assign w_pad_ext  = SW'(pad_q);
    assign o_pad_zero = pad_zero_q;
`else
    assign w_pad_ext  = '0;
`endif

    always_comb begin
        state_d    = state_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        size_d     = size_q;
        k_d        = k_q;
        stride_d   = stride_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        base_row_d = base_row_q;
        base_col_d = base_col_q;
        row_addr_d = row_addr_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        done_d     = done_q;
`ifdef ROUTER_PAD_EN
        pad_d      = pad_q;
        pad_zero_d = pad_zero_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_en) begin
                    state_d  = S_LOAD;
                    ox_d     = i_o_x;
                    oy_d     = i_o_y;
                    size_d   = i_i_size;
                    k_d      = i_k_size;
                    stride_d = i_stride;
`ifdef ROUTER_PAD_EN
                    pad_d    = i_pad;
`endif
                end
            end
            S_LOAD: begin
                base_row_d = SW'(ox_q) * SW'(stride_q) - w_pad_ext;
                base_col_d = SW'(oy_q) * SW'(stride_q) - w_pad_ext;
                row_addr_d = base_row_d[RW-1:0] * RW'(size_q);
                kx_d       = '0;
                ky_d       = '0;
                if (k_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_GEN;
                    valid_d = 1'b1;
                end
            end
            S_GEN: begin
                if (i_ready) begin
                    if (ky_q == k_q - 1'b1) begin
                        ky_d = '0;
                        if (kx_q == k_q - 1'b1) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            kx_d       = kx_q + 1'b1;
                            row_addr_d = row_addr_q + RW'(size_q);
                        end
                    end else begin
                        ky_d = ky_q + 1'b1;
                    end
                end
            end
            default: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
        endcase

        if (i_reg_clear) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end

        // Address of the element to be presented next; held across stalls since the _d terms hold.
        w_lin = row_addr_d + base_col_d[RW-1:0] + RW'(ky_d);
`ifdef ROUTER_PAD_EN
        w_row    = base_row_d + SW'(kx_d);
        w_col    = base_col_d + SW'(ky_d);
        w_in_map = !w_row[SW-1] && (w_row < SW'(size_q)) &&
                   !w_col[SW-1] && (w_col < SW'(size_q));
        if (state_d == S_GEN) begin
            pad_zero_d = !w_in_map;
            addr_d     = w_in_map ? w_lin[SRAM_ADDR_WIDTH-1:0] : '0;
        end
`else
        if (state_d == S_GEN) begin
            addr_d = w_lin[SRAM_ADDR_WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            ox_q       <= '0;
            oy_q       <= '0;
            size_q     <= '0;
            k_q        <= '0;
            stride_q   <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            base_row_q <= '0;
            base_col_q <= '0;
            row_addr_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef ROUTER_PAD_EN
            pad_q      <= '0;
            pad_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            size_q     <= size_d;
            k_q        <= k_d;
            stride_q   <= stride_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            base_row_q <= base_row_d;
            base_col_q <= base_col_d;
            row_addr_q <= row_addr_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
`ifdef ROUTER_PAD_EN
            pad_q      <= pad_d;
            pad_zero_q <= pad_zero_d;
`endif
        end
    end

    assign o_addr  = addr_q;
    assign o_valid = valid_q;
    assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_row_router_addr_gen.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for row_router_addr_gen: window order, stalls, clear, k=0 and padding.
module tb_row_router_addr_gen;
    localparam int AW  = 8;
    localparam int SAW = 16;

    logic           i_clk       = 1'b0;
    logic           i_nrst      = 1'b0;
    logic           i_reg_clear = 1'b0;
    logic           i_en        = 1'b0;
    logic           i_ready     = 1'b0;
    logic [AW-1:0]  i_o_x       = '0;
    logic [AW-1:0]  i_o_y       = '0;
    logic [AW-1:0]  i_i_size    = '0;
    logic [AW-1:0]  i_k_size    = '0;
    logic [AW-1:0]  i_stride    = '0;
`ifdef ROUTER_PAD_EN
    logic [AW-1:0]  i_pad       = '0;
    logic           o_pad_zero;
`endif
    logic [SAW-1:0] o_addr;
    logic           o_valid;
    logic           o_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SAW:0] exp_q[$];   // {pad_zero, addr}

    always #5 i_clk = ~i_clk;

    row_router_addr_gen #(.ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SAW)) dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_reg_clear (i_reg_clear),
        .i_en        (i_en),
        .i_o_x       (i_o_x),
        .i_o_y       (i_o_y),
        .i_i_size    (i_i_size),
        .i_k_size    (i_k_size),
        .i_stride    (i_stride),
`ifdef ROUTER_PAD_EN
        .i_pad       (i_pad),
        .o_pad_zero  (o_pad_zero),
`endif
        .i_ready     (i_ready),
        .o_addr      (o_addr),
        .o_valid     (o_valid),
        .o_done      (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: row-major window, column (ky) innermost.
    task automatic push_window(input int size, input int k, input int s,
                               input int ox, input int oy, input int pad);
        for (int kx = 0; kx < k; kx++) begin
            for (int ky = 0; ky < k; ky++) begin
                int   r;
                int   c;
                int   a;
                logic pz;
                r  = ox * s + kx - pad;
                c  = oy * s + ky - pad;
                a  = r * size + c;
                pz = 1'b0;
`ifdef ROUTER_PAD_EN
                if (r < 0 || r >= size || c < 0 || c >= size) begin
                    pz = 1'b1;
                    a  = 0;
                end
`endif
                exp_q.push_back({pz, a[SAW-1:0]});
            end
        end
    endtask

    // mode: 0 = ready always high, 1 = ready 1,0,0 repeating, 2 = random ready.
    // clear_at >= 0 asserts i_reg_clear during the transfer with that index.
    task automatic run_case(input int size, input int k, input int s, input int ox,
                            input int oy, input int pad, input int mode, input int clear_at);
        int           cyc;
        int           pops;
        bit           aborted;
        logic [SAW:0] e;
        cyc     = 0;
        pops    = 0;
        aborted = 1'b0;
        i_i_size = AW'(size);
        i_k_size = AW'(k);
        i_stride = AW'(s);
        i_o_x    = AW'(ox);
        i_o_y    = AW'(oy);
`ifdef ROUTER_PAD_EN
        i_pad    = AW'(pad);
`endif
        i_en     = 1'b1;
        push_window(size, k, s, ox, oy, pad);

        @(posedge i_clk); #1;
        // Inputs are captured on the sampling edge; scribble over them to prove it.
        i_o_x = '1; i_o_y = '1; i_i_size = '1; i_k_size = '1; i_stride = '1;
        chk("load_valid", o_valid, 0);
        chk("load_done", o_done, 0);

        @(posedge i_clk); #1;
        if (k == 0) begin
            chk("k0_valid", o_valid, 0);
            chk("k0_done", o_done, 1);
        end else begin
            chk("first_valid", o_valid, 1);
        end

        while (exp_q.size() > 0 && cyc < 400 && !aborted) begin
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 3 == 0);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            if (clear_at >= 0 && pops == clear_at) begin
                i_ready     = 1'b1;
                i_reg_clear = 1'b1;
                i_en        = 1'b0;
            end
            @(negedge i_clk);
            e = exp_q[0];
            chk("gen_valid", o_valid, 1);
            chk("addr", o_addr, e[SAW-1:0]);
`ifdef ROUTER_PAD_EN
            chk("pad_zero", o_pad_zero, e[SAW]);
`endif
            if (o_valid && i_ready) begin
                void'(exp_q.pop_front());
                pops++;
            end
            @(posedge i_clk); #1;
            cyc++;
            if (i_reg_clear) begin
                aborted     = 1'b1;
                i_reg_clear = 1'b0;
                chk("clr_valid", o_valid, 0);
                chk("clr_done", o_done, 0);
                exp_q.delete();
            end
        end
        if (exp_q.size() != 0) begin
            chk("timeout_left", exp_q.size(), 0);
            exp_q.delete();
        end

        if (aborted) begin
            @(posedge i_clk); #1;
            chk("idle_valid", o_valid, 0);
        end else begin
            if (k > 0) begin
                chk("done", o_done, 1);
                chk("valid_off", o_valid, 0);
                if (mode == 0) chk("cycles", cyc, k * k);
            end
            for (int i = 0; i < 3; i++) begin
                @(posedge i_clk); #1;
                chk("hold_done", o_done, 1);
                chk("hold_valid", o_valid, 0);
            end
            i_en    = 1'b0;
            i_ready = 1'b0;
            @(posedge i_clk); #1;
            chk("idle_done", o_done, 0);
        end
    endtask

    initial begin
        int size;
        int k;
        int s;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_done", o_done, 0);
        chk("rst_addr", o_addr, 0);
        i_nrst = 1'b1;
        @(posedge i_clk); #1;

        run_case(5, 3, 1, 1, 2, 0, 0, -1);   // 7,8,9,12,13,14,17,18,19
        run_case(7, 2, 2, 1, 1, 0, 0, -1);   // 16,17,23,24
        run_case(5, 3, 1, 1, 2, 0, 1, -1);   // stalled ready
        run_case(5, 0, 1, 1, 2, 0, 0, -1);   // empty window
        run_case(5, 3, 1, 1, 2, 0, 0, 3);    // clear on 4th transfer
        run_case(5, 3, 1, 1, 2, 0, 0, -1);   // replay from 7

        for (int t = 0; t < 3; t++) begin
            size = int'($urandom_range(3, 9));
            k    = int'($urandom_range(1, 3));
            s    = int'($urandom_range(1, 2));
            run_case(size, k, s, int'($urandom_range(0, (size - k) / s)),
                     int'($urandom_range(0, (size - k) / s)), 0, 2, -1);
        end

`ifdef ROUTER_PAD_EN
        run_case(4, 3, 1, 0, 0, 1, 0, -1);   // pz 1,1,1,1,0,0,1,0,0 / 0,0,0,0,0,1,0,4,5
        run_case(4, 3, 1, 0, 0, 1, 1, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
